// File: rtl/he_lut_builder.sv
// Histogram-equalization LUT builder: sweeps 256 histogram bins, accumulates the
// CDF and writes LUT[k] = min(255, (CDF[k]*255) >> NUM_PIXELS_LOG2), one per cycle.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start
// S_READ  | issuing histogram read addresses 0..255
// S_DRAIN | last read data in flight, final LUT write pending
// S_DONE  | one-cycle completion pulse; a new start is accepted here
module he_lut_builder #(
    parameter int NUM_PIXELS_LOG2 = 18,
    parameter int BIN_W           = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [7:0]       hist_rd_addr,
    input  logic [BIN_W-1:0] hist_rd_data,
    output logic             lut_wr_en,
    output logic [7:0]       lut_wr_addr,
    output logic [7:0]       lut_wr_data,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int CDF_W  = NUM_PIXELS_LOG2 + 2;
    localparam int PROD_W = CDF_W + 8;
    localparam logic [NUM_PIXELS_LOG2:0] CDF_FULL = {1'b1, {NUM_PIXELS_LOG2{1'b0}}};
    localparam logic [CDF_W-1:0]         CDF_MAX  = {1'b0, CDF_FULL};

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic                     accept;
    logic                     data_vld;
    logic [7:0]               data_idx;
    logic [NUM_PIXELS_LOG2:0] cdf;
    logic [CDF_W-1:0]         cdf_next;
    logic                     cdf_over;
    logic [PROD_W-1:0]        prod;
    logic [PROD_W-1:0]        prod_shift;
    logic [7:0]               lut_val;

    assign accept = start && ((state == S_IDLE) || (state == S_DONE));
    assign busy   = (state == S_READ) || (state == S_DRAIN);
    assign done   = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_READ;
            S_READ:  if (hist_rd_addr == 8'd255) state_nx = S_DRAIN;
            S_DRAIN: if (lut_wr_en && (lut_wr_addr == 8'd255)) state_nx = S_DONE;
            S_DONE:  state_nx = start ? S_READ : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // x*255 as (x<<8)-x; anything at or above 256 after the shift clamps to 255
    always_comb begin
        cdf_next   = CDF_W'(cdf) + CDF_W'(hist_rd_data);
        cdf_over   = cdf_next > CDF_MAX;
        prod       = (PROD_W'(cdf_next) << 8) - PROD_W'(cdf_next);
        prod_shift = prod >> NUM_PIXELS_LOG2;
        lut_val    = (|prod_shift[PROD_W-1:8]) ? 8'hFF : prod_shift[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_rd_addr <= 8'd0;
            data_vld     <= 1'b0;
            data_idx     <= 8'd0;
            cdf          <= '0;
            lut_wr_en    <= 1'b0;
            lut_wr_addr  <= 8'd0;
            lut_wr_data  <= 8'd0;
            overflow     <= 1'b0;
        end else begin
            // read data returns one cycle after its address
            data_vld  <= (state == S_READ);
            data_idx  <= hist_rd_addr;
            lut_wr_en <= data_vld;

            if (accept) begin
                hist_rd_addr <= 8'd0;
                cdf          <= '0;
                overflow     <= 1'b0;
            end else if (state == S_READ) begin
                hist_rd_addr <= hist_rd_addr + 8'd1;
            end

            if (data_vld) begin
                cdf         <= cdf_over ? CDF_FULL : cdf_next[NUM_PIXELS_LOG2:0];
                lut_wr_addr <= data_idx;
                lut_wr_data <= lut_val;
                if (cdf_over) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/he_lut_builder.md
# he_lut_builder

Builds the 256-entry histogram-equalization mapping LUT from a completed 512×512 frame histogram. It sits downstream of the histogram accumulation RAM and upstream of the pixel remap stage that produces `pixel_out`. On `start` it sweeps all 256 bins, forms the running CDF, and writes `LUT[k] = min(255, (CDF[k]*255) >> 18)` into the remap LUT, one entry per cycle.

## Interface
- `NUM_PIXELS_LOG2`, 18, log2 of pixels per frame (512*512 = 262144)
- `BIN_W`, 19, histogram bin count width (must hold 2^18)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset; one clock, synchronous reset, active-high
- `start`  in  1  single-cycle request to build the LUT; honoured only while `busy`=0
- `hist_rd_addr`  out  8  histogram RAM read address (registered)
- `hist_rd_data`  in  BIN_W  bin count; valid exactly 1 cycle after the address
- `lut_wr_en`  out  1  LUT write strobe
- `lut_wr_addr`  out  8  LUT write address
- `lut_wr_data`  out  8  equalized level
- `busy`  out  1  sweep in progress
- `done`  out  1  1-cycle pulse after last LUT write
- `overflow`  out  1  sticky: CDF exceeded 2^NUM_PIXELS_LOG2 during the last sweep

## Operation
- States: IDLE, READ (issuing addresses 0..255), DRAIN (waiting on last data/write), DONE (1 cycle, returns to IDLE).
- IDLE + `start`=1: clear CDF to 0, clear `overflow`, go READ with `hist_rd_addr`=0.
- READ: increment `hist_rd_addr` each cycle; after address 255 go DRAIN.
- Each returned bin k: `cdf_next = cdf + hist_rd_data` in 20 bits; if `cdf_next` > 2^18, saturate CDF to 2^18 and set `overflow`.
- LUT value: `(cdf_next*255) >> 18` computed as `(cdf_next<<8) - cdf_next`, 28-bit intermediate; clamp to 255. Registered into `lut_wr_data` with `lut_wr_addr`=k, `lut_wr_en`=1.
- Writes strictly ascending 0..255, exactly 256 per sweep, no gaps.
- `start` while `busy`=1 ignored (no restart, no effect on CDF).
- `start` in the `done` cycle is accepted (`busy` is 0 there).
- `reset` at any time: state IDLE, CDF 0, all outputs 0 on next cycle; no further writes from the aborted sweep; `done` does not pulse.
- Reset values: `hist_rd_addr`=0, `lut_wr_en`=0, `lut_wr_addr`=0, `lut_wr_data`=0, `busy`=0, `done`=0, `overflow`=0.

## Timing
- Cycle S: `start` sampled high in IDLE.
- S+1: `busy`=1, `hist_rd_addr`=0; address k driven at S+1+k, last (255) at S+256.
- `hist_rd_data` for bin k valid at S+2+k.
- `lut_wr_en`=1 with `lut_wr_addr`=k at S+3+k; last write S+258.
- S+259: `done`=1, `busy`=0. `busy` high S+1..S+258 (258 cycles).
- Start-to-done latency 259 cycles; back-to-back start at S+259 gives next first write at S+262.
- `overflow` valid from the write cycle of the offending bin; held until next accepted `start` or `reset`.

## Test plan
- Constant frame: bin 100 = 262144, others 0 -> LUT[0..99]=0, LUT[100..255]=255, `overflow`=0.
- Flat histogram: every bin 1024 -> LUT[k]=k for all k (CDF[255]=2^18 gives 255), `overflow`=0.
- Overfull histogram: every bin 2048 -> LUT[k]=(2048(k+1)*255)>>18 for k≤127 (LUT[127]=255), CDF saturates at bin 128, LUT[128..255]=255, `overflow`=1 from write 128 until next `start`.
- Cycle check: `start` at S -> first `lut_wr_en` at S+3, exactly 256 ascending writes, `done` only at S+259; `start` pulses at S+10 and S+200 ignored; `start` at S+259 accepted.
- Reset mid-sweep: assert `reset` while `lut_wr_addr`=50 -> next cycle all outputs 0, no writes, no `done`; subsequent `start` gives full 256-write sweep with correct values and `overflow` cleared.
